// File: rtl/fsbm_pkg.sv
// Shared types for the full-search block-matching controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default SAD width, all-ones SAD sentinel, controller state enum,
//           and the candidate position record carried down the valid pipeline.
package fsbm_pkg;

  localparam int SAD_W = 12;
  localparam logic [SAD_W-1:0] SAD_MAX = '1;

  // Position fields are sized for windows up to 256x256; the controller
  // zero-extends its narrower counters into them.
  localparam int POS_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } pos_t;

endpackage

// File: rtl/sad_min_tracker.sv
// Running minimum of PE sums with the position that produced it.
// Latency: best_* reflect a valid sample on the cycle after it is sampled.
// Backpressure: none; every valid sample is consumed on the edge it arrives.
// Ports: clk, rst_n (sync, active-low), clear (restart tracking), sample/pos/pe_sum
//        (one aligned PE result), best_sad/best_x/best_y (current minimum).
//        With SAD_EARLY_EXIT_EN: early_thresh in, thresh_hit out (sticky until clear).
module sad_min_tracker
  import fsbm_pkg::*;
#(
  parameter int SAD_W = fsbm_pkg::SAD_W,
  parameter int XW    = 4,
  parameter int YW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample,
  input  pos_t             pos,
  input  logic [SAD_W-1:0] pe_sum,
`ifdef SAD_EARLY_EXIT_EN
  input  logic [SAD_W-1:0] early_thresh,
  output logic             thresh_hit,
`endif
  output logic [SAD_W-1:0] best_sad,
  output logic [XW-1:0]    best_x,
  output logic [YW-1:0]    best_y
);

  logic             first_q;
  logic [SAD_W-1:0] sad_q;
  pos_t             pos_q;
  logic             take;

  // The first result is always taken so an all-ones SAD still records its
  // position; afterwards only a strictly smaller sum wins, so the earliest
  // raster position survives ties.
  assign take = sample && (first_q || (pe_sum < sad_q));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      first_q <= 1'b1;
      sad_q   <= '1;
      pos_q   <= '0;
    end else if (take) begin
      first_q <= 1'b0;
      sad_q   <= pe_sum;
      pos_q   <= pos;
    end
  end

`ifdef SAD_EARLY_EXIT_EN
  logic hit_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hit_q <= 1'b0;
    end else if (take && (pe_sum <= early_thresh)) begin
      hit_q <= 1'b1;
    end
  end

  assign thresh_hit = hit_q;
`endif

  assign best_sad = sad_q;
  assign best_x   = XW'(pos_q.x);
  assign best_y   = YW'(pos_q.y);

  // Upper position bits are always zero for the configured window.
  logic unused_pos_bits;
  assign unused_pos_bits = ^{pos_q.x, pos_q.y};

endmodule

// File: rtl/sad_search_ctrl.sv
// Sequences one raster full-search pass of a 4x4 SAD PE and keeps the best match.
// Latency: SEARCH_W*SEARCH_H + PE_LAT + 2 cycles start->done with cand_ready high.
// Backpressure: cand_ready low stalls issue indefinitely; position and cand_req hold.
// Ports: clk, rst_n (sync, active-low), start; cand_req/cand_ready/cand_x/cand_y
//        toward the window buffer; pe_enable/pe_sum to/from the PE; busy, done,
//        best_sad/best_x/best_y results.
// Optional macro SAD_EARLY_EXIT_EN adds early_thresh in / early_exit out: a new
// best at or below the threshold stops issuing and the pass drains early.
module sad_search_ctrl
  import fsbm_pkg::*;
#(
  parameter  int SEARCH_W = 16,
  parameter  int SEARCH_H = 16,
  parameter  int PE_LAT   = 2,
  parameter  int SAD_W    = fsbm_pkg::SAD_W,
  localparam int XW       = $clog2(SEARCH_W),
  localparam int YW       = $clog2(SEARCH_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             cand_req,
  input  logic             cand_ready,
  output logic [XW-1:0]    cand_x,
  output logic [YW-1:0]    cand_y,
  output logic             pe_enable,
  input  logic [SAD_W-1:0] pe_sum,
  output logic             busy,
  output logic             done,
`ifdef SAD_EARLY_EXIT_EN
  input  logic [SAD_W-1:0] early_thresh,
  output logic             early_exit,
`endif
  output logic [SAD_W-1:0] best_sad,
  output logic [XW-1:0]    best_x,
  output logic [YW-1:0]    best_y
);

  state_t        state, state_nxt;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          accept;
  logic          fire;
  logic          last_pos;
  logic          stop_scan;

  // Stage i holds the fire issued i edges ago; stage PE_LAT lines up with
  // the edge on which the PE presents that candidate's sum.
  logic [PE_LAT:1] vld_pipe;
  pos_t            pos_pipe [1:PE_LAT];

`ifdef SAD_EARLY_EXIT_EN
  logic thresh_hit;
  logic early_q;
  assign stop_scan = thresh_hit;
`else
  assign stop_scan = 1'b0;
`endif

  assign accept    = (state == IDLE) && start;
  assign fire      = cand_req && cand_ready;
  assign pe_enable = fire;
  assign last_pos  = (x_q == XW'(SEARCH_W - 1)) && (y_q == YW'(SEARCH_H - 1));
  assign cand_x    = x_q;
  assign cand_y    = y_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_req  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        // Once a threshold hit is registered no further candidate fires.
        cand_req = !stop_scan;
        if (stop_scan || (fire && last_pos)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (vld_pipe == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raster position counters; they wrap within range even after the final fire.
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      x_q <= '0;
      y_q <= '0;
    end else if (fire) begin
      if (x_q == XW'(SEARCH_W - 1)) begin
        x_q <= '0;
        y_q <= (y_q == YW'(SEARCH_H - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= fire;
      for (int i = 2; i <= PE_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  // Position payload needs no reset: it is only consumed under vld_pipe.
  always_ff @(posedge clk) begin
    pos_pipe[1] <= '{x: POS_W'(x_q), y: POS_W'(y_q)};
    for (int i = 2; i <= PE_LAT; i++) begin
      pos_pipe[i] <= pos_pipe[i-1];
    end
  end

`ifdef SAD_EARLY_EXIT_EN
  // Records that issuing was cut short; a hit arriving after the window was
  // fully issued does not count as an early exit.
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      early_q <= 1'b0;
    end else if ((state == SCAN) && thresh_hit) begin
      early_q <= 1'b1;
    end
  end

  assign early_exit = early_q && ((state == DONE) || (state == IDLE));
`endif

  sad_min_tracker #(
    .SAD_W (SAD_W),
    .XW    (XW),
    .YW    (YW)
  ) u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (accept),
    .sample       (vld_pipe[PE_LAT]),
    .pos          (pos_pipe[PE_LAT]),
    .pe_sum       (pe_sum),
`ifdef SAD_EARLY_EXIT_EN
    .early_thresh (early_thresh),
    .thresh_hit   (thresh_hit),
`endif
    .best_sad     (best_sad),
    .best_x       (best_x),
    .best_y       (best_y)
  );

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl on a 4x4 window with a 2-cycle behavioural PE.
// Table-driven search vectors with a result scoreboard, plus abort/start-pulse sequences.
module tb_sad_search_ctrl;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int LAT = 2;
  localparam int SW  = 12;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          start      = 1'b0;
  logic          cand_ready = 1'b0;
  logic          cand_req, pe_enable, busy, done;
  logic [1:0]    cand_x, cand_y, best_x, best_y;
  logic [SW-1:0] best_sad;
  logic [SW-1:0] pe_sum = '0;
  logic [SW-1:0] pe_s1  = '0;
`ifdef SAD_EARLY_EXIT_EN
  logic [SW-1:0] early_thresh = '0;
  logic          early_exit;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sad_search_ctrl #(
    .SEARCH_W (W),
    .SEARCH_H (H),
    .PE_LAT   (LAT),
    .SAD_W    (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cand_req     (cand_req),
    .cand_ready   (cand_ready),
    .cand_x       (cand_x),
    .cand_y       (cand_y),
    .pe_enable    (pe_enable),
    .pe_sum       (pe_sum),
    .busy         (busy),
    .done         (done),
`ifdef SAD_EARLY_EXIT_EN
    .early_thresh (early_thresh),
    .early_exit   (early_exit),
`endif
    .best_sad     (best_sad),
    .best_x       (best_x),
    .best_y       (best_y)
  );

  // Behavioural PE: sum for the position enabled at edge k appears for the
  // edge k+2, zero in every other slot.
  int sad_map [16];
  always @(posedge clk) begin
    pe_s1  <= pe_enable ? SW'(sad_map[cand_y * W + cand_x]) : '0;
    pe_sum <= pe_s1;
  end

  typedef struct {
    int ramp;
    int ax, ay, av;
    int bx, by, bv;
    int other;
    bit rnd;
    int thr;
    int exp_sad, exp_x, exp_y, exp_cyc;
    int min_en, max_en;
    int exp_early;
  } vec_t;

  typedef struct {
    int sad, x, y;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   nvec;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic vec_t mk(input int ramp, input int ax, input int ay, input int av,
                              input int bx, input int by, input int bv, input int other,
                              input bit rnd, input int es, input int ex, input int ey,
                              input int ecyc);
    vec_t v;
    v.ramp = ramp; v.ax = ax; v.ay = ay; v.av = av;
    v.bx = bx; v.by = by; v.bv = bv; v.other = other; v.rnd = rnd;
    v.thr = 0; v.exp_sad = es; v.exp_x = ex; v.exp_y = ey; v.exp_cyc = ecyc;
    v.min_en = W * H; v.max_en = W * H; v.exp_early = 0;
    return v;
  endfunction

  task automatic fill_map(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      sad_map[i] = (v.ramp != 0) ? (100 + (i % 4) + 4 * (i / 4)) : v.other;
    end
    if (v.av >= 0) sad_map[v.ay * W + v.ax] = v.av;
    if (v.bv >= 0) sad_map[v.by * W + v.bx] = v.bv;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cand_req"}, cand_req, 0);
    chk({tag, "_cand_x"},   cand_x,   0);
    chk({tag, "_cand_y"},   cand_y,   0);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_done"},     done,     0);
    chk({tag, "_best_sad"}, best_sad, 4095);
    chk({tag, "_best_x"},   best_x,   0);
    chk({tag, "_best_y"},   best_y,   0);
  endtask

  // One search: expected result goes on the scoreboard when start is driven
  // and is popped when done appears. Optionally pulses start mid-scan and in
  // the done cycle; both must be ignored.
  task automatic run_vec(input vec_t v, input bit extra_start, input string tag);
    int   k, nen, px, py;
    bit   got, prev_stall, hold_ok, idle_ok, stable_ok;
    exp_t e;
    fill_map(v);
`ifdef SAD_EARLY_EXIT_EN
    early_thresh = SW'(v.thr);
`endif
    @(negedge clk);
    start      = 1'b1;
    cand_ready = 1'b1;
    sb.push_back('{v.exp_sad, v.exp_x, v.exp_y});
    k = 0; nen = 0; px = 0; py = 0;
    got = 0; prev_stall = 0; hold_ok = 1;
    e = '{0, 0, 0};
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      start = extra_start && (k == 5);
      if (done) begin
        got   = 1;
        start = extra_start;
        e     = sb.pop_front();
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_best_sad"}, best_sad, e.sad);
        chk({tag, "_best_x"}, best_x, e.x);
        chk({tag, "_best_y"}, best_y, e.y);
        if (v.exp_cyc >= 0) chk({tag, "_latency"}, k, v.exp_cyc);
`ifdef SAD_EARLY_EXIT_EN
        chk({tag, "_early_exit"}, early_exit, v.exp_early);
`endif
      end else begin
        cand_ready = v.rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
        #1;
        if (pe_enable) nen++;
        if (prev_stall && (cand_x != px || cand_y != py || !cand_req)) hold_ok = 0;
        prev_stall = cand_req && !cand_ready;
        px = cand_x;
        py = cand_y;
      end
    end
    if (!got) begin
      chk({tag, "_done_timeout"}, 0, 1);
      e = sb.pop_front();
    end
    chk_range({tag, "_pe_enable_count"}, nen, v.min_en, v.max_en);
    chk({tag, "_stall_hold"}, hold_ok, 1);
    idle_ok = 1; stable_ok = 1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done) idle_ok = 0;
      if (best_sad != e.sad || best_x != e.x || best_y != e.y) stable_ok = 0;
    end
    chk({tag, "_idle_after_done"}, idle_ok, 1);
    chk({tag, "_best_stable"}, stable_ok, 1);
  endtask

  task automatic abort_seq();
    int  k, nen;
    bit  no_done;
    fill_map(vecs[0]);
    @(negedge clk);
    start = 1'b1; cand_ready = 1'b1;
    k = 0; nen = 0;
    while (nen < 9 && k < 100) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      #1;
      if (pe_enable) nen++;
    end
    chk("abort_reached_cand9", nen, 9);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("abort");
    rst_n = 1'b1;
    no_done = 1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (done || busy) no_done = 0;
    end
    chk("abort_no_done", no_done, 1);
  endtask

  initial begin
    nvec = 0;
    vecs[nvec++] = mk(1, 2, 1, 7,    0, 0, -1, 0,    0, 7,    2, 1, 20);
    vecs[nvec++] = mk(0, 1, 0, 5,    3, 3, 5,  50,   0, 5,    1, 0, 20);
    vecs[nvec++] = mk(1, 2, 1, 7,    0, 0, -1, 0,    1, 7,    2, 1, -1);
    vecs[nvec++] = mk(0, 0, 0, -1,   0, 0, -1, 4095, 0, 4095, 0, 0, 20);
    vecs[nvec++] = mk(1, 3, 3, 1,    0, 0, -1, 0,    0, 1,    3, 3, 20);
    vecs[nvec++] = mk(0, 0, 0, -1,   0, 0, -1, 9,    1, 9,    0, 0, -1);
`ifdef SAD_EARLY_EXIT_EN
    vecs[nvec] = mk(0, 1, 0, 3, 0, 0, -1, 50, 0, 3, 1, 0, -1);
    vecs[nvec].thr = 10;
    vecs[nvec].min_en = 2;
    vecs[nvec].max_en = 6;
    vecs[nvec].exp_early = 1;
    nvec++;
`endif

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < nvec; i++) begin
      run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end
    run_vec(vecs[1], 1'b1, "extra_start");
    abort_seq();
    run_vec(vecs[0], 1'b0, "after_abort");
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/sad_search_ctrl.md
Name: sad_search_ctrl

Overview:
Sequences one full-search pass of a single 4x4 SAD processing element over a SEARCH_W x SEARCH_H candidate window. Issues candidate positions in raster order to the search-window buffer and gates the PE enable. Aligns returning PE sums with their positions through a latency-matched valid pipeline. Tracks the minimum SAD and its motion vector, then reports completion with a done pulse.

Parameters:
SEARCH_W, 16, candidate columns per search (x = 0..SEARCH_W-1)
SEARCH_H, 16, candidate rows per search (y = 0..SEARCH_H-1)
PE_LAT, 2, cycles from the PE enable sample edge to the edge where the PE sum is sampled
SAD_W, 12, PE sum width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
start  in  1  single-cycle request to begin a search; ignored while busy=1
cand_req  out  1  candidate position valid toward the window buffer
cand_ready  in  1  window buffer is presenting pixels for cand_x/cand_y this cycle
cand_x  out  $clog2(SEARCH_W)  candidate column
cand_y  out  $clog2(SEARCH_H)  candidate row
pe_enable  out  1  combinational cand_req & cand_ready; drives the PE enable
pe_sum  in  SAD_W  PE result; zero outside valid slots
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; best_* are stable from this cycle until the next start
best_sad  out  SAD_W  minimum SAD of the last search
best_x  out  $clog2(SEARCH_W)  column of the minimum
best_y  out  $clog2(SEARCH_H)  row of the minimum

Behaviour:
- Reset values (rst_n=0 at posedge): state=IDLE; cand_req=0, cand_x=0, cand_y=0, busy=0, done=0; best_sad={SAD_W{1}}; best_x=0, best_y=0; valid pipeline cleared.
- Reset mid-search aborts immediately. No done pulse is produced, and results from the aborted search are discarded.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: start=1 -> SCAN. cand_x=cand_y=0, best_sad=all-ones, first-result flag set.
  - SCAN: cand_req=1. A fire (cand_req & cand_ready) advances x; at x=SEARCH_W-1, x wraps to 0 and y increments. A fire at (SEARCH_W-1, SEARCH_H-1) -> DRAIN, with cand_req=0 next cycle.
  - If cand_ready=0 in SCAN, position and cand_req hold (stall). Unlimited stall length is allowed.
  - DRAIN: cand_req=0. Stays until the valid pipeline is empty, then -> DONE.
  - DONE: done=1 for one cycle -> IDLE. busy drops in the same cycle as the done pulse.
- Valid pipeline: PE_LAT-deep shift register of {fire, x, y}. pe_sum is sampled at the edge where the stage PE_LAT bit is 1; no other pe_sum value is ever used.
- Update rule: on a valid sample, replace best_* if the first-result flag is set or pe_sum < best_sad (strict). On ties, the earliest raster position wins.
- Throughput: 1 candidate/cycle with cand_ready tied high. A full search takes SEARCH_W*SEARCH_H + PE_LAT + 2 cycles from start to done.
- start arriving in the DONE cycle is ignored; start is accepted only in IDLE.
- No arithmetic is performed on pe_sum other than an unsigned compare. Position counters never exceed their range.

Optional Feature:
SAD_EARLY_EXIT_EN:
- Defined:
  - Adds input early_thresh [SAD_W-1:0] and output early_exit [1].
  - After any best-SAD update with new best_sad <= early_thresh, SCAN stops issuing (-> DRAIN).
  - In-flight results still update best_*.
  - early_exit is high with done and stays high until the next start.
- Undefined: the port is absent and the full window is always searched.

Decomposition:
- Package fsbm_pkg holds:
  - SAD_W
  - SAD_MAX (all-ones)
  - state enum {IDLE, SCAN, DRAIN, DONE}
  - a position struct {x, y}
- Natural sub-module: sad_min_tracker. It contains the valid-gated compare, the first-result flag, and the best_sad/best_x/best_y registers, with a clear input driven from start.

Test Plan:
- SEARCH_W=SEARCH_H=4, cand_ready=1, model PE returns 100+x+4y except 7 at (2,1) -> done at cycle 16+2+2 after start; best_sad=7, best_x=2, best_y=1.
- Ties: SAD=5 at (1,0) and (3,3), others 50 -> best=(1,0), best_sad=5.
- cand_ready random 30% low -> identical best_* as the no-stall run; cand_x/cand_y hold during stalls; pe_enable count = 16.
- rst_n pulsed low at candidate 9 -> all outputs at reset values next cycle, no done. New start -> clean full search and correct result.
- start pulsed during SCAN and in the DONE cycle -> ignored; exactly one done per accepted start.
- SAD_EARLY_EXIT_EN, early_thresh=10, SAD=3 at (1,0) -> issuing stops within 2 fires after the update; done=1, early_exit=1, best=(1,0), best_sad=3.
